pll_phase_arbiter: RTL

Shares the PLL dynamic phase-shift port (PHASECOUNTERSELECT / PHASEUPDOWN / PHASESTEP / PHASEDONE) between two independent requesters (e.g. the Avalon register path and an on-chip calibration sweeper). It arbitrates round-robin, then executes a multi-step phase-shift job for the winner. Each step follows the Cyclone IV PHASESTEP/PHASEDONE handshake. Completion or timeout is reported back to the requester. It sits between the requesters and the PLL in the CLK50M (PLL scanclk) domain.

---
 rtl/pll_phase_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/pll_phase_arbiter.sv
// Round-robin arbiter in front of the PLL dynamic phase-shift port.
// Runs a multi-step PHASESTEP/PHASEDONE job for the winning requester and reports done/error back.
module pll_phase_arbiter #(
    parameter int P_STEP_W  = 8,
    parameter int P_TIMEOUT = 255
) (
    input  logic                CLK50M,
    input  logic                RESET_N,
    input  logic                REQ0_VALID,
    input  logic [3:0]          REQ0_SEL,
    input  logic                REQ0_UPDN,
    input  logic [P_STEP_W-1:0] REQ0_STEPS,
    output logic                REQ0_ACK,
    output logic                REQ0_DONE,
    output logic                REQ0_ERR,
    input  logic                REQ1_VALID,
    input  logic [3:0]          REQ1_SEL,
    input  logic                REQ1_UPDN,
    input  logic [P_STEP_W-1:0] REQ1_STEPS,
    output logic                REQ1_ACK,
    output logic                REQ1_DONE,
    output logic                REQ1_ERR,
    input  logic                PHASEDONE,
    output logic [3:0]          PHASECOUNTERSELECT,
    output logic                PHASEUPDOWN,
    output logic                PHASESTEP,
    output logic                BUSY,
    output logic                GRANT
);

    localparam int P_CNT_W = (P_TIMEOUT < 2) ? 1 : $clog2(P_TIMEOUT + 1);
    localparam logic [P_CNT_W-1:0] LP_CNT_LAST = P_CNT_W'(P_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STEP1,
        S_STEP2,
        S_WAIT_LO,
        S_WAIT_HI,
        S_NEXT,
        S_FIN
    } state_t;

    state_t                r_state;
    logic                  r_pd_meta;
    logic                  r_pd_s;
    logic [3:0]            r_sel;
    logic                  r_updn;
    logic [P_STEP_W-1:0]   r_remain;
    logic [P_CNT_W-1:0]    r_cnt;
    logic                  r_step;
    logic                  r_busy;
    logic                  r_grant;
    logic                  r_last;
    logic [1:0]            r_ack;
    logic [1:0]            r_done;
    logic [1:0]            r_err;

    logic                  w_any;
    logic                  w_win;
    logic [3:0]            w_sel;
    logic                  w_updn;
    logic [P_STEP_W-1:0]   w_steps;

    // On a tie the requester that was not served last wins.
    assign w_any   = REQ0_VALID | REQ1_VALID;
    assign w_win   = (REQ0_VALID & REQ1_VALID) ? ~r_last : REQ1_VALID;
    assign w_sel   = w_win ? REQ1_SEL   : REQ0_SEL;
    assign w_updn  = w_win ? REQ1_UPDN  : REQ0_UPDN;
    assign w_steps = w_win ? REQ1_STEPS : REQ0_STEPS;

    always_ff @(posedge CLK50M) begin
        if (!RESET_N) begin
            r_state   <= S_IDLE;
            r_pd_meta <= 1'b1;
            r_pd_s    <= 1'b1;
            r_sel     <= '0;
            r_updn    <= 1'b0;
            r_remain  <= '0;
            r_cnt     <= '0;
            r_step    <= 1'b0;
            r_busy    <= 1'b0;
            r_grant   <= 1'b0;
            r_last    <= 1'b1;
            r_ack     <= '0;
            r_done    <= '0;
            r_err     <= '0;
        end else begin
            r_pd_meta <= PHASEDONE;
            r_pd_s    <= r_pd_meta;
            r_ack     <= '0;
            r_done    <= '0;
            r_err     <= '0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state      <= S_SETUP;
                        r_busy       <= 1'b1;
                        r_grant      <= w_win;
                        r_ack[w_win] <= 1'b1;
                        r_sel        <= w_sel;
                        r_updn       <= w_updn;
                        r_remain     <= w_steps;
                    end
                end
                S_SETUP: begin
                    if (r_sel > 4'h6) begin
                        r_state         <= S_FIN;
                        r_done[r_grant] <= 1'b1;
                        r_err[r_grant]  <= 1'b1;
                    end else if (r_remain == '0) begin
                        r_state         <= S_FIN;
                        r_done[r_grant] <= 1'b1;
                    end else begin
                        r_state <= S_STEP1;
                        r_step  <= 1'b1;
                    end
                end
                S_STEP1: begin
                    r_state <= S_STEP2;
                    r_cnt   <= '0;
                end
                S_STEP2: begin
                    r_state <= S_WAIT_LO;
                    r_step  <= 1'b0;
                    r_cnt   <= '0;
                end
                // The timeout counter spans both wait phases of one step.
                S_WAIT_LO: begin
                    if (r_cnt == LP_CNT_LAST) begin
                        r_state         <= S_FIN;
                        r_done[r_grant] <= 1'b1;
                        r_err[r_grant]  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + P_CNT_W'(1);
                        if (!r_pd_s) begin
                            r_state <= S_WAIT_HI;
                        end
                    end
                end
                S_WAIT_HI: begin
                    if (r_cnt == LP_CNT_LAST) begin
                        r_state         <= S_FIN;
                        r_done[r_grant] <= 1'b1;
                        r_err[r_grant]  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + P_CNT_W'(1);
                        if (r_pd_s) begin
                            r_state <= S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    r_remain <= r_remain - P_STEP_W'(1);
                    if (r_remain == P_STEP_W'(1)) begin
                        r_state         <= S_FIN;
                        r_done[r_grant] <= 1'b1;
                    end else begin
                        r_state <= S_STEP1;
                        r_step  <= 1'b1;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_last  <= r_grant;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign REQ0_ACK           = r_ack[0];
    assign REQ1_ACK           = r_ack[1];
    assign REQ0_DONE          = r_done[0];
    assign REQ1_DONE          = r_done[1];
    assign REQ0_ERR           = r_err[0];
    assign REQ1_ERR           = r_err[1];
    assign PHASECOUNTERSELECT = r_sel;
    assign PHASEUPDOWN        = r_updn;
    assign PHASESTEP          = r_step;
    assign BUSY               = r_busy;
    assign GRANT              = r_grant;

endmodule
